// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes, size encodings, FSM states and strobe helper for the MEM-stage
// data-memory access controller.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] size_strobe(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return 4'b0011 << lo;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_strobe_gen.sv
// Decodes the MEM-stage op and low address bits into bus size, byte strobes and
// direction; alignment errors only reported when MEM_ALIGN_CHECK_EN is defined.
module mem_strobe_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0] op,
    input  logic [1:0] addr_lo,
    output logic [1:0] data_size,
    output logic [3:0] data_wstrb,
    output logic       data_wr,
    output logic       is_load,
    output logic       is_store,
    output logic       addr_err
);

    always_comb begin
        data_size = SIZE_BYTE;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (op)
            EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; data_size = SIZE_BYTE; end
            EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; data_size = SIZE_HALF; end
            EXE_LW_OP:             begin is_load  = 1'b1; data_size = SIZE_WORD; end
            EXE_SB_OP:             begin is_store = 1'b1; data_size = SIZE_BYTE; end
            EXE_SH_OP:             begin is_store = 1'b1; data_size = SIZE_HALF; end
            EXE_SW_OP:             begin is_store = 1'b1; data_size = SIZE_WORD; end
            default: ;
        endcase
    end

    // Reads never assert strobes; the load-extend logic picks the lane itself.
    assign data_wr    = is_store;
    assign data_wstrb = is_store ? size_strobe(data_size, addr_lo) : 4'b0000;

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err = (is_load | is_store) &
                      (((data_size == SIZE_HALF) & addr_lo[0]) |
                       ((data_size == SIZE_WORD) & (addr_lo != 2'b00)));
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: drives the req/addr_ok/data_ok bus and
// stalls the pipeline until the transfer completes. Option: MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memenM,
    input  logic [7:0]        alucontrolM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedata2M,
    input  logic              flushM,
    input  logic              stallM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] readdataM,
    output logic              stall_memM,
    output logic              adelM,
    output logic              adesM,
    output logic [ADDR_W-1:0] badvaddrM
);

    state_t            state, state_n;
    logic              killed, killed_n;
    logic              load_cmd, cap_en, start;
    logic [1:0]        sg_size;
    logic [3:0]        sg_wstrb;
    logic              sg_wr, is_load, is_store, addr_err;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cap_q;

    mem_strobe_gen u_strobe (
        .op         (alucontrolM),
        .addr_lo    (aluoutM[1:0]),
        .data_size  (sg_size),
        .data_wstrb (sg_wstrb),
        .data_wr    (sg_wr),
        .is_load    (is_load),
        .is_store   (is_store),
        .addr_err   (addr_err)
    );

    // Gated by rst so every output is quiet while reset is held.
    assign start = ~rst & memenM & (is_load | is_store) & ~flushM & ~addr_err &
                   (state == ST_IDLE);

    assign adelM     = ~rst & memenM & is_load & addr_err;
    assign adesM     = ~rst & memenM & is_store & addr_err;
    assign badvaddrM = (adelM | adesM) ? aluoutM : '0;

    always_comb begin
        state_n    = state;
        killed_n   = killed;
        load_cmd   = 1'b0;
        cap_en     = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'b00;
        data_addr  = '0;
        data_wdata = '0;
        data_wstrb = 4'b0000;
        readdataM  = '0;
        stall_memM = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    data_req   = 1'b1;
                    data_wr    = sg_wr;
                    data_size  = sg_size;
                    data_addr  = aluoutM;
                    data_wdata = writedata2M;
                    data_wstrb = sg_wstrb;
                    stall_memM = 1'b1;
                    killed_n   = 1'b0;
                    if (data_addr_ok) begin
                        state_n = ST_WAIT;
                    end else begin
                        state_n  = ST_REQ;
                        load_cmd = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                data_req   = 1'b1;
                data_wr    = wr_q;
                data_size  = size_q;
                data_addr  = addr_q;
                data_wdata = wdata_q;
                data_wstrb = wstrb_q;
                stall_memM = 1'b1;
                if (flushM) killed_n = 1'b1;
                if (data_addr_ok) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (flushM) killed_n = 1'b1;
                // A flushed transfer still runs to data_ok; its data is dropped.
                if (data_data_ok) begin
                    killed_n = 1'b0;
                    if (~killed & ~flushM) begin
                        readdataM = data_rdata;
                        if (stallM) begin
                            state_n = ST_DONE;
                            cap_en  = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    stall_memM = 1'b1;
                end
            end
            ST_DONE: begin
                readdataM = cap_q;
                if (~stallM) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            killed  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            wstrb_q <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
        end else begin
            state  <= state_n;
            killed <= killed_n;
            if (load_cmd) begin
                wr_q    <= sg_wr;
                size_q  <= sg_size;
                wstrb_q <= sg_wstrb;
                addr_q  <= aluoutM;
                wdata_q <= writedata2M;
            end
            if (cap_en) cap_q <= data_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: single-transfer vector table plus hand-written
// sequences for delayed handshakes, DONE hold, flush and reset in REQ.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, flushM, stallM;
    logic [7:0]  alucontrolM;
    logic [31:0] aluoutM, writedata2M;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, readdataM, badvaddrM;
    logic [3:0]  data_wstrb;
    logic        stall_memM, adelM, adesM;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .alucontrolM(alucontrolM),
        .aluoutM(aluoutM), .writedata2M(writedata2M), .flushM(flushM), .stallM(stallM),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .readdataM(readdataM), .stall_memM(stall_memM), .adelM(adelM), .adesM(adesM),
        .badvaddrM(badvaddrM)
    );

    logic [106:0] bus_o;
    assign bus_o = {data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
                    stall_memM, adelM, adesM, badvaddrM};

    typedef struct packed {
        logic        memen;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;
        logic [31:0] rdata;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic        adel;
        logic        ades;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memenM = 1'b0; alucontrolM = 8'h00; aluoutM = 32'h0; writedata2M = 32'h0;
        flushM = 1'b0; stallM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'h0;
    endtask

    function automatic vec_t mk(input logic memen, input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic flush, input logic [31:0] rdata,
                                input logic req, input logic wr, input logic [1:0] size,
                                input logic [3:0] wstrb, input logic adel, input logic ades);
        vec_t v;
        v = '{memen, op, addr, wdata, flush, rdata, req, wr, size, wstrb, adel, ades};
        return v;
    endfunction

    function automatic logic [106:0] exp_bus(input vec_t v);
        return {v.req, v.req ? v.wr : 1'b0, v.req ? v.size : 2'b00,
                v.req ? v.addr : 32'h0, v.req ? v.wdata : 32'h0, v.req ? v.wstrb : 4'h0,
                v.req, v.adel, v.ades, (v.adel | v.ades) ? v.addr : 32'h0};
    endfunction

    int req_cnt, stall_cnt, addr_bad;

    initial begin
        vecs[0]  = mk(1, EXE_SW_OP,  32'h100, 32'hDEADBEEF, 0, 32'h0,        1, 1, 2, 4'b1111, 0, 0);
        vecs[1]  = mk(1, EXE_SB_OP,  32'h103, 32'h5A5A5A5A, 0, 32'h0,        1, 1, 0, 4'b1000, 0, 0);
        vecs[2]  = mk(1, EXE_SH_OP,  32'h102, 32'hBEEFBEEF, 0, 32'h0,        1, 1, 1, 4'b1100, 0, 0);
        vecs[3]  = mk(1, EXE_SB_OP,  32'h101, 32'h3C3C3C3C, 0, 32'h0,        1, 1, 0, 4'b0010, 0, 0);
        vecs[4]  = mk(1, EXE_LB_OP,  32'h101, 32'h0,        0, 32'h11223344, 1, 0, 0, 4'b0000, 0, 0);
        vecs[5]  = mk(1, EXE_LHU_OP, 32'h200, 32'h0,        0, 32'hA5A50000, 1, 0, 1, 4'b0000, 0, 0);
        vecs[6]  = mk(1, EXE_LW_OP,  32'h204, 32'h0,        0, 32'h87654321, 1, 0, 2, 4'b0000, 0, 0);
        vecs[7]  = mk(1, 8'h21,      32'h300, 32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 0, 0);
        vecs[8]  = mk(0, EXE_SW_OP,  32'h100, 32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 0, 0);
        vecs[9]  = mk(1, EXE_SW_OP,  32'h100, 32'h0,        1, 32'h0,        0, 0, 0, 4'b0000, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        vecs[10] = mk(1, EXE_LH_OP,  32'h201, 32'h0,        0, 32'h0,        0, 0, 0, 4'b0000, 1, 0);
        vecs[11] = mk(1, EXE_SH_OP,  32'h201, 32'h77777777, 0, 32'h0,        0, 0, 0, 4'b0000, 0, 1);
        vecs[12] = mk(1, EXE_SW_OP,  32'h102, 32'h0BADF00D, 0, 32'h0,        0, 0, 0, 4'b0000, 0, 1);
`else
        vecs[10] = mk(1, EXE_LH_OP,  32'h201, 32'h0,        0, 32'h0,        1, 0, 1, 4'b0000, 0, 0);
        vecs[11] = mk(1, EXE_SH_OP,  32'h201, 32'h77777777, 0, 32'h0,        1, 1, 1, 4'b0110, 0, 0);
        vecs[12] = mk(1, EXE_SW_OP,  32'h102, 32'h0BADF00D, 0, 32'h0,        1, 1, 2, 4'b1111, 0, 0);
`endif
        vecs[13] = mk(1, EXE_LBU_OP, 32'h203, 32'h0,        0, 32'hFFEEDDCC, 1, 0, 0, 4'b0000, 0, 0);

        // reset state, including a live op held during reset
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_idle", {21'h0, bus_o}, 128'h0);
        chk("reset_rdata", {96'h0, readdataM}, 128'h0);
        memenM = 1'b1; alucontrolM = EXE_SW_OP; aluoutM = 32'h100; writedata2M = 32'h1;
        data_addr_ok = 1'b1;
        #1;
        chk("reset_gated", {21'h0, bus_o}, 128'h0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();

        // single transfers: request cycle with immediate addr_ok, then data_ok
        for (int i = 0; i < NV; i++) begin
            memenM = vecs[i].memen; alucontrolM = vecs[i].op; aluoutM = vecs[i].addr;
            writedata2M = vecs[i].wdata; flushM = vecs[i].flush; data_addr_ok = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_bus", i), {21'h0, bus_o}, {21'h0, exp_bus(vecs[i])});
            tick();
            memenM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0;
            data_data_ok = 1'b1; data_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), {95'h0, stall_memM, readdataM},
                {96'h0, vecs[i].req ? vecs[i].rdata : 32'h0});
            tick();
            idle_inputs();
        end

        // LW with addr_ok after 3 wait cycles and data_ok 2 cycles later
        req_cnt = 0; stall_cnt = 0; addr_bad = 0;
        memenM = 1'b1; alucontrolM = EXE_LW_OP; aluoutM = 32'h200;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) aluoutM = 32'hFFFFFFF0;
            if (c >= 6) memenM = 1'b0;
            data_addr_ok = (c == 3);
            data_data_ok = (c == 5);
            data_rdata   = (c == 5) ? 32'h12345678 : 32'h0;
            @(negedge clk);
            if (data_req) begin
                req_cnt++;
                if (data_addr != 32'h200 || data_size != SIZE_WORD) addr_bad++;
            end
            if (stall_memM) stall_cnt++;
            if (c == 5) chk("lw_slow_rdata", {96'h0, readdataM}, {96'h0, 32'h12345678});
            tick();
        end
        chk("lw_slow_req_cycles", {96'h0, 32'(req_cnt)}, 128'd4);
        chk("lw_slow_stall_cycles", {96'h0, 32'(stall_cnt)}, 128'd5);
        chk("lw_slow_addr_stable", {96'h0, 32'(addr_bad)}, 128'd0);
        idle_inputs();
        tick();

        // LW with external stall held across data_ok: DONE holds the word
        memenM = 1'b1; alucontrolM = EXE_LW_OP; aluoutM = 32'h300; stallM = 1'b1;
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("done_req", {127'h0, data_req}, 128'h1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("done_dok_rdata", {95'h0, stall_memM, readdataM}, {96'h0, 32'hCAFEF00D});
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("done_hold%0d", k), {94'h0, data_req, stall_memM, readdataM},
                {96'h0, 32'hCAFEF00D});
            tick();
        end
        stallM = 1'b0;
        @(negedge clk);
        chk("done_release", {94'h0, data_req, stall_memM, readdataM}, {96'h0, 32'hCAFEF00D});
        tick();
        memenM = 1'b0;
        @(negedge clk);
        chk("done_back_idle", {94'h0, data_req, stall_memM, readdataM}, 128'h0);
        idle_inputs();
        tick();

        // flush while waiting: stall held to data_ok, load data dropped
        memenM = 1'b1; alucontrolM = EXE_LW_OP; aluoutM = 32'h400; data_addr_ok = 1'b1;
        @(negedge clk);
        tick();
        data_addr_ok = 1'b0; flushM = 1'b1;
        @(negedge clk);
        chk("flush_wait_stall0", {127'h0, stall_memM}, 128'h1);
        tick();
        flushM = 1'b0;
        @(negedge clk);
        chk("flush_wait_stall1", {127'h0, stall_memM}, 128'h1);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h99999999;
        @(negedge clk);
        chk("flush_dok", {95'h0, stall_memM, readdataM}, 128'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("flush_idle", {94'h0, data_req, stall_memM, readdataM}, 128'h0);
        tick();

        // reset asserted while in REQ; the late response must be ignored
        memenM = 1'b1; alucontrolM = EXE_SW_OP; aluoutM = 32'h500; writedata2M = 32'h55;
        @(negedge clk);
        chk("rstreq_issue", {127'h0, data_req}, 128'h1);
        tick();
        @(negedge clk);
        chk("rstreq_in_req", {21'h0, bus_o},
            {21'h0, 1'b1, 1'b1, SIZE_WORD, 32'h500, 32'h55, 4'b1111, 1'b1, 1'b0, 1'b0, 32'h0});
        #1 rst = 1'b1;
        #1;
        chk("rstreq_outputs", {21'h0, bus_o}, 128'h0);
        chk("rstreq_rdata", {96'h0, readdataM}, 128'h0);
        tick();
        idle_inputs();
        rst = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hDEAD0000;
        @(negedge clk);
        chk("rstreq_stale_resp", {95'h0, stall_memM, readdataM}, 128'h0);
        tick();
        idle_inputs();
        memenM = 1'b1; alucontrolM = EXE_SW_OP; aluoutM = 32'h600; writedata2M = 32'h66;
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rstreq_new_req", {95'h0, data_req, data_addr}, {95'h0, 1'b1, 32'h600});
        tick();
        idle_inputs();
        data_data_ok = 1'b1;
        tick();
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
